lam_unit: RTL and testbench
===========================

// Module: lam_unit
// PURPOSE
//   Load/store ("LAM") execution unit; consumes the lam_* command fields produced by the instruction decoder.
//   Captures the ALU-computed effective address and runs one RV32I memory access over a req/ack data-memory port.
//   Stores: aligns and byte-enables the store data. Loads: extracts and sign/zero-extends the read data, then writes rd.
//   Drives busy so fetch/decode stall while an access is outstanding.
// PARAMETERS
//   MEM_TIMEOUT  16  max cycles mem_req may wait for mem_ack before the access aborts with err
// PORTS
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-high reset
//   lam_new      in   1   decoder: new load/store this cycle
//   lam_rw       in   1   decoder: 1 = store, 0 = load
//   lam_type     in   3   decoder: funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   lam_rs       in   5   decoder: store-data source register index
//   lam_sel_out  in   5   decoder: load destination register index
//   addr         in   32  ALU result (rs1 + imm), valid in the lam_new cycle
//   rf_sel       out  5   register-file read select (store data)
//   rf_data      in   32  register-file read data for rf_sel, combinational
//   mem_req      out  1   memory request, held until mem_ack
//   mem_we       out  1   1 = write
//   mem_addr     out  32  word-aligned address {addr[31:2],2'b00}
//   mem_be       out  4   byte enables
//   mem_wdata    out  32  lane-aligned store data
//   mem_ack      in   1   memory completes access; mem_rdata is valid in the same cycle
//   mem_rdata    in   32  read word
//   wb_en        out  1   register write strobe, one cycle
//   wb_sel       out  5   destination register
//   wb_data      out  32  extended load result
//   busy         out  1   access in progress; upstream must hold lam_new low
//   err          out  1   one-cycle pulse: misaligned, illegal lam_type, or timeout
// BEHAVIOUR
//   Reset: state=IDLE, all outputs 0, internal registers 0.
//   FSM states: IDLE, FETCH_RS, REQ, WB.
//   IDLE: busy=0.
//     On lam_new, capture rw, type, rs, sel_out, and addr.
//     Check legality: for loads, type must be 000/001/010/100/101; for stores, type must be 000/001/010.
//     Check alignment: H requires addr[0]=0; W requires addr[1:0]=0.
//     If illegal or misaligned: pulse err the next cycle, stay in IDLE, no memory access.
//     Otherwise: store -> FETCH_RS; load -> REQ.
//   FETCH_RS (1 cycle): rf_sel=lam_rs. Register rf_data shifted into its byte lane by addr[1:0]. -> REQ.
//   REQ: mem_req=1. mem_we, mem_addr, mem_be, and mem_wdata stay stable until ack.
//     mem_be values: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'hF. Loads use the same be.
//     On mem_ack: mem_req drops in the next cycle. Store -> IDLE. Load -> latch extracted data, go to WB.
//     Extraction: byte/half selected by addr[1:0]; B/H sign-extend, BU/HU zero-extend.
//     Timeout counter is cleared on entry to REQ and increments each REQ cycle without ack.
//     At MEM_TIMEOUT cycles: drop mem_req, pulse err, -> IDLE, no wb.
//   WB (1 cycle): wb_en=1 unless sel_out==0 (x0 is never written); wb_sel and wb_data valid. -> IDLE.
//   busy=1 in every state except IDLE. It rises the cycle after lam_new.
//     Upstream must gate lam_new with busy combinationally.
//   Latency, ack in the first REQ cycle: load = lam_new -> wb_en in 3 cycles; store = 3 cycles to mem_ack.
//   lam_new while busy: ignored; no capture.
//   mem_ack outside REQ: ignored.
//   Reset mid-access: everything returns to the reset state immediately; mem_req drops asynchronously; no wb, no err.
//   Register outputs (mem_*, wb_*, err) come from flops. busy and rf_sel may be decoded from state.
// STRUCTURE
//   Shared package/defines (shared with decoder): LAM_LOAD/LAM_STORE, funct3 codes LB..LHU/SB..SW, FSM state encodings.
//   One natural sub-module: lam_align, purely combinational.
//     Store side: be generation and write-lane shift.
//     Load side: read extraction and sign/zero extension.
//   lam_unit holds the FSM, capture registers, and timeout counter.
// TESTING
//   1. LW addr=0x100, mem_rdata=0xDEADBEEF, ack after 2 cycles -> mem_be=F, mem_addr=0x100; wb_sel=rd, wb_data=0xDEADBEEF.
//   2. LB/LBU addr=0x103, rdata=0x80xxxxxx -> be=1000; LB wb_data=0xFFFFFF80, LBU wb_data=0x00000080.
//   3. SH addr=0x202, rf_data=0x1234ABCD -> mem_we=1, be=1100, wdata[31:16]=0xABCD, no wb_en.
//   4. LH addr=0x101 and SW addr=0x102 -> err pulse, mem_req never asserted, busy stays 0.
//   5. LW with mem_ack withheld -> after 16 REQ cycles mem_req=0, err=1 for one cycle, no wb; a following LW completes normally.
//   6. reset asserted during REQ -> mem_req=0 immediately, no wb/err; lam_new while busy dropped; load to x0 -> no wb_en.

Source files
------------

// File: rtl/lam_unit_pkg.sv
// rtl/lam_unit_pkg.sv - shared load/store command encodings, FSM states and legality helpers
package lam_unit_pkg;

    localparam logic LAM_LOAD  = 1'b0;
    localparam logic LAM_STORE = 1'b1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FETCH_RS = 2'd1;
    localparam logic [1:0] ST_REQ      = 2'd2;
    localparam logic [1:0] ST_WB       = 2'd3;

    function automatic logic lam_legal(input logic rw, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (rw == LAM_STORE) begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        return ok;
    endfunction

    // Size is carried in funct3[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic lam_aligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b1;
        if (f3[1:0] == 2'b01) begin
            ok = (addr_lo[0] == 1'b0);
        end else if (f3[1:0] == 2'b10) begin
            ok = (addr_lo == 2'b00);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lam_align.sv
// rtl/lam_align.sv - combinational byte-enable, store lane shift and load extraction
module lam_align
    import lam_unit_pkg::*;
(
    input  logic [2:0]  lam_type_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rd_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] st_lane_o,
    output logic [31:0] ld_data_o
);

    logic [4:0]  shamt;
    logic [31:0] rd_shift;

    assign shamt     = {addr_lo_i, 3'b000};
    assign st_lane_o = st_data_i << shamt;
    assign rd_shift  = rd_word_i >> shamt;

    always_comb begin
        be_o = 4'hF;
        case (lam_type_i[1:0])
            2'b00:   be_o = 4'b0001 << addr_lo_i;
            2'b01:   be_o = 4'b0011 << addr_lo_i;
            default: be_o = 4'hF;
        endcase
    end

    always_comb begin
        ld_data_o = rd_word_i;
        case (lam_type_i)
            F3_LB:   ld_data_o = {{24{rd_shift[7]}}, rd_shift[7:0]};
            F3_LBU:  ld_data_o = {24'd0, rd_shift[7:0]};
            F3_LH:   ld_data_o = {{16{rd_shift[15]}}, rd_shift[15:0]};
            F3_LHU:  ld_data_o = {16'd0, rd_shift[15:0]};
            default: ld_data_o = rd_word_i;
        endcase
    end

endmodule

// File: rtl/lam_unit.sv
// rtl/lam_unit.sv - load/store execution unit: capture, FSM, timeout and memory/writeback flops
module lam_unit
    import lam_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lam_new,
    input  logic        lam_rw,
    input  logic [2:0]  lam_type,
    input  logic [4:0]  lam_rs,
    input  logic [4:0]  lam_sel_out,
    input  logic [31:0] addr,
    output logic [4:0]  rf_sel,
    input  logic [31:0] rf_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_sel,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        err
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic          rw_q, rw_d;
    logic [2:0]    type_q, type_d;
    logic [4:0]    rs_q, rs_d;
    logic [4:0]    sel_q, sel_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          wb_en_q, wb_en_d;
    logic [4:0]    wb_sel_q, wb_sel_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          err_q, err_d;

    logic [2:0]  al_type;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_be;
    logic [31:0] al_lane;
    logic [31:0] al_ld;

    // In IDLE a load launches straight from the decoder fields, so align the live inputs.
    assign al_type    = (state_q == ST_IDLE) ? lam_type  : type_q;
    assign al_addr_lo = (state_q == ST_IDLE) ? addr[1:0] : addr_q[1:0];

    lam_align u_align (
        .lam_type_i (al_type),
        .addr_lo_i  (al_addr_lo),
        .st_data_i  (rf_data),
        .rd_word_i  (mem_rdata),
        .be_o       (al_be),
        .st_lane_o  (al_lane),
        .ld_data_o  (al_ld)
    );

    assign busy      = (state_q != ST_IDLE);
    assign rf_sel    = (state_q == ST_FETCH_RS) ? rs_q : 5'd0;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_en     = wb_en_q;
    assign wb_sel    = wb_sel_q;
    assign wb_data   = wb_data_q;
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        type_d      = type_q;
        rs_d        = rs_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        wb_en_d     = 1'b0;
        wb_sel_d    = wb_sel_q;
        wb_data_d   = wb_data_q;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (lam_new) begin
                    rw_d   = lam_rw;
                    type_d = lam_type;
                    rs_d   = lam_rs;
                    sel_d  = lam_sel_out;
                    addr_d = addr;
                    if (!lam_legal(lam_rw, lam_type) || !lam_aligned(lam_type, addr[1:0])) begin
                        err_d = 1'b1;
                    end else if (lam_rw == LAM_STORE) begin
                        state_d = ST_FETCH_RS;
                    end else begin
                        state_d    = ST_REQ;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {addr[31:2], 2'b00};
                        mem_be_d   = al_be;
                        cnt_d      = '0;
                    end
                end
            end
            ST_FETCH_RS: begin
                state_d     = ST_REQ;
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = {addr_q[31:2], 2'b00};
                mem_be_d    = al_be;
                mem_wdata_d = al_lane;
                cnt_d       = '0;
            end
            ST_REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (rw_q == LAM_STORE) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_WB;
                        wb_data_d = al_ld;
                        wb_sel_d  = sel_q;
                        wb_en_d   = (sel_q != 5'd0);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rw_q        <= 1'b0;
            type_q      <= 3'd0;
            rs_q        <= 5'd0;
            sel_q       <= 5'd0;
            addr_q      <= 32'd0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            wb_en_q     <= 1'b0;
            wb_sel_q    <= 5'd0;
            wb_data_q   <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            type_q      <= type_d;
            rs_q        <= rs_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            wb_en_q     <= wb_en_d;
            wb_sel_q    <= wb_sel_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_lam_unit.sv
// tb/tb_lam_unit.sv - self-checking bench for lam_unit with a behavioural access model
module tb_lam_unit;

    logic        clk;
    logic        reset;
    logic        lam_new;
    logic        lam_rw;
    logic [2:0]  lam_type;
    logic [4:0]  lam_rs;
    logic [4:0]  lam_sel_out;
    logic [31:0] addr;
    logic [4:0]  rf_sel;
    logic [31:0] rf_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_en;
    logic [4:0]  wb_sel;
    logic [31:0] wb_data;
    logic        busy;
    logic        err;

    logic [31:0] rf [32];
    int checks;
    int failures;

    assign rf_data = rf[rf_sel];

    lam_unit #(.MEM_TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .lam_new     (lam_new),
        .lam_rw      (lam_rw),
        .lam_type    (lam_type),
        .lam_rs      (lam_rs),
        .lam_sel_out (lam_sel_out),
        .addr        (addr),
        .rf_sel      (rf_sel),
        .rf_data     (rf_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .wb_en       (wb_en),
        .wb_sel      (wb_sel),
        .wb_data     (wb_data),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int acc_size(input logic [2:0] t);
        if (t[1:0] == 2'b00) return 1;
        if (t[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic model_ok(input logic rw, input logic [2:0] t, input logic [31:0] a);
        int sz;
        bit legal;
        sz = acc_size(t);
        legal = rw ? (t == 3'd0 || t == 3'd1 || t == 3'd2)
                   : (t == 3'd0 || t == 3'd1 || t == 3'd2 || t == 3'd4 || t == 3'd5);
        return legal && ((a % sz) == 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] t, input logic [31:0] a);
        int sz;
        sz = acc_size(t);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] v, input logic [31:0] a);
        longint unsigned x;
        x = longint'(v) * (longint'(1) << (8 * (a % 4)));
        return x[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] w, input logic [31:0] a);
        longint unsigned v;
        int sz;
        sz = acc_size(t);
        v = longint'(w) / (longint'(1) << (8 * (a % 4)));
        if (sz == 1) begin
            v = v % 256;
            if (t == 3'd0 && v >= 128) v = v + 64'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v % 65536;
            if (t == 3'd1 && v >= 32768) v = v + 64'hFFFF_0000;
        end
        return v[31:0];
    endfunction

    task automatic run_access(input string nm, input logic rw, input logic [2:0] t,
                              input logic [4:0] rs, input logic [4:0] rd,
                              input logic [31:0] a, input logic [31:0] rdata, input int dly);
        logic [31:0] stv;
        stv = rf[rs];
        lam_new = 1'b1; lam_rw = rw; lam_type = t; lam_rs = rs; lam_sel_out = rd; addr = a;
        step();
        lam_new = 1'b0; lam_type = 3'($urandom); addr = $urandom;
        if (!model_ok(rw, t, a)) begin
            chk({nm, ".err"}, 32'(err), 32'd1);
            chk({nm, ".busy"}, 32'(busy), 32'd0);
            chk({nm, ".req"}, 32'(mem_req), 32'd0);
            step();
            chk({nm, ".err_pulse"}, 32'(err), 32'd0);
            chk({nm, ".req2"}, 32'(mem_req), 32'd0);
            return;
        end
        chk({nm, ".busy"}, 32'(busy), 32'd1);
        if (rw) begin
            chk({nm, ".early_req"}, 32'(mem_req), 32'd0);
            chk({nm, ".rf_sel"}, 32'(rf_sel), 32'(rs));
            step();
        end
        chk({nm, ".req"}, 32'(mem_req), 32'd1);
        chk({nm, ".we"}, 32'(mem_we), 32'(rw));
        chk({nm, ".addr"}, mem_addr, a & 32'hFFFF_FFFC);
        chk({nm, ".be"}, 32'(mem_be), 32'(model_be(t, a)));
        if (rw) chk({nm, ".wdata"}, mem_wdata, model_wdata(stv, a));
        for (int i = 0; i < dly; i++) begin
            step();
            chk({nm, ".hold"}, 32'(mem_req), 32'd1);
        end
        mem_ack = 1'b1; mem_rdata = rdata;
        step();
        mem_ack = 1'b0; mem_rdata = $urandom;
        chk({nm, ".req_drop"}, 32'(mem_req), 32'd0);
        if (rw) begin
            chk({nm, ".st_wb"}, 32'(wb_en), 32'd0);
            chk({nm, ".st_idle"}, 32'(busy), 32'd0);
        end else begin
            chk({nm, ".wb_en"}, 32'(wb_en), 32'(rd != 5'd0));
            if (rd != 5'd0) begin
                chk({nm, ".wb_sel"}, 32'(wb_sel), 32'(rd));
                chk({nm, ".wb_data"}, wb_data, model_load(t, rdata, a));
            end
            step();
            chk({nm, ".wb_pulse"}, 32'(wb_en), 32'd0);
            chk({nm, ".ld_idle"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int n;
        logic [2:0] lt [5];
        logic [2:0] t;
        logic rw;
        logic [31:0] a;
        checks = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'd0;
        rf[7] = 32'h1234_ABCD;
        lam_new = 1'b0; lam_rw = 1'b0; lam_type = 3'd0; lam_rs = 5'd0;
        lam_sel_out = 5'd0; addr = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        reset = 1'b1;
        step();
        chk("rst.req", 32'(mem_req), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.wb_en", 32'(wb_en), 32'd0);
        chk("rst.wb_data", wb_data, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.rf_sel", 32'(rf_sel), 32'd0);
        step();
        reset = 1'b0;
        step();

        run_access("lw", 1'b0, 3'b010, 5'd0, 5'd5, 32'h100, 32'hDEAD_BEEF, 2);
        run_access("lb", 1'b0, 3'b000, 5'd0, 5'd6, 32'h103, 32'h8012_3456, 0);
        run_access("lbu", 1'b0, 3'b100, 5'd0, 5'd6, 32'h103, 32'h8012_3456, 1);
        run_access("sh", 1'b1, 3'b001, 5'd7, 5'd0, 32'h202, 32'd0, 0);
        chk("sh.wdata_hi", 32'(mem_wdata[31:16]), 32'h0000_ABCD);
        run_access("lh_mis", 1'b0, 3'b001, 5'd0, 5'd3, 32'h101, 32'd0, 0);
        run_access("sw_mis", 1'b1, 3'b010, 5'd2, 5'd0, 32'h102, 32'd0, 0);
        run_access("ld_ill", 1'b0, 3'b011, 5'd0, 5'd3, 32'h100, 32'd0, 0);
        run_access("st_ill", 1'b1, 3'b100, 5'd2, 5'd0, 32'h100, 32'd0, 0);

        // Withheld ack: mem_req must stay up exactly 16 cycles.
        lam_new = 1'b1; lam_rw = 1'b0; lam_type = 3'b010; lam_sel_out = 5'd9; addr = 32'h300;
        step();
        lam_new = 1'b0;
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            step();
        end
        chk("to.cycles", 32'(n), 32'd16);
        chk("to.err", 32'(err), 32'd1);
        chk("to.wb_en", 32'(wb_en), 32'd0);
        chk("to.busy", 32'(busy), 32'd0);
        step();
        chk("to.err_pulse", 32'(err), 32'd0);
        chk("to.wb_en2", 32'(wb_en), 32'd0);
        run_access("lw_after_to", 1'b0, 3'b010, 5'd0, 5'd9, 32'h304, 32'hCAFE_F00D, 0);

        // Reset during REQ: request drops without waiting for a clock edge.
        lam_new = 1'b1; lam_rw = 1'b0; lam_type = 3'b010; lam_sel_out = 5'd4; addr = 32'h400;
        step();
        lam_new = 1'b0;
        chk("mid.req", 32'(mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid.req_async", 32'(mem_req), 32'd0);
        chk("mid.busy", 32'(busy), 32'd0);
        chk("mid.err", 32'(err), 32'd0);
        step();
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        mem_ack = 1'b0;
        chk("mid.no_wb", 32'(wb_en), 32'd0);
        chk("mid.ack_idle", 32'(busy), 32'd0);
        chk("mid.err2", 32'(err), 32'd0);

        // lam_new while busy is dropped.
        lam_new = 1'b1; lam_rw = 1'b0; lam_type = 3'b010; lam_sel_out = 5'd8; addr = 32'h500;
        step();
        lam_type = 3'b000; lam_sel_out = 5'd10; addr = 32'h601;
        step();
        lam_new = 1'b0;
        chk("busy.addr_kept", mem_addr, 32'h500);
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_5A5A;
        step();
        mem_ack = 1'b0;
        chk("busy.wb_sel", 32'(wb_sel), 32'd8);
        chk("busy.wb_data", wb_data, 32'hA5A5_5A5A);
        step();
        step();
        chk("busy.no_second", 32'(mem_req), 32'd0);
        chk("busy.no_wb2", 32'(wb_en), 32'd0);

        run_access("ld_x0", 1'b0, 3'b010, 5'd0, 5'd0, 32'h700, 32'h7777_7777, 0);

        lt[0] = 3'd0; lt[1] = 3'd1; lt[2] = 3'd2; lt[3] = 3'd4; lt[4] = 3'd5;
        for (int k = 0; k < 40; k++) begin
            rw = 1'($urandom);
            t = rw ? lt[$urandom_range(0, 2)] : lt[$urandom_range(0, 4)];
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(acc_size(t)) - 32'd1);
            run_access("rand", rw, t, 5'($urandom), 5'($urandom), a, $urandom,
                       int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
